// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one registered ALU among NUM_REQ requesters.
// One operation in flight: accept in IDLE, wait out the ALU latency, then hold the response.
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [OP_W-1:0]           alu_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int CNT_W = $clog2(ALU_LAT + 1) + 1;
  localparam logic [ID_W:0]    L_NUM = (ID_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] L_LAT = CNT_W'(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [CNT_W-1:0]    r_lat_cnt;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_rsp_data;

  logic [2*NUM_REQ-1:0] w_rot;
  logic                 w_win_found;
  logic [ID_W:0]        w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_win_id;
  logic [ID_W:0]        w_win_inc;
  logic [ID_W-1:0]      w_rr_next;
  logic                 w_accept;
  logic                 w_lat_done;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; lowest set bit wins.
  always_comb begin
    w_rot       = {req_valid, req_valid} >> r_rr_ptr;
    w_win_found = 1'b0;
    w_off       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_win_found = 1'b1;
        w_off       = (ID_W + 1)'(k);
      end
    end
    w_sum     = {1'b0, r_rr_ptr} + w_off;
    w_win_id  = (w_sum >= L_NUM) ? ID_W'(w_sum - L_NUM) : w_sum[ID_W-1:0];
    w_win_inc = {1'b0, w_win_id} + 1'b1;
    w_rr_next = (w_win_inc == L_NUM) ? '0 : w_win_inc[ID_W-1:0];
  end

  assign w_accept   = (r_state == S_IDLE) && w_win_found;
  assign w_lat_done = (r_lat_cnt == L_LAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_win_found) w_state_next = S_EXEC;
      S_EXEC:  if (w_lat_done) w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready = NUM_REQ'(1) << w_win_id;
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

  // Hold registers change only on accept, so the ALU sees stable operands for the whole EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_lat_cnt  <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_rr_ptr  <= w_rr_next;
      r_id      <= w_win_id;
      r_lat_cnt <= '0;
      r_op      <= req_opcode[w_win_id*OP_W +: OP_W];
      r_a       <= req_a[w_win_id*DATA_W +: DATA_W];
      r_b       <= req_b[w_win_id*DATA_W +: DATA_W];
    end else if (r_state == S_EXEC) begin
      r_lat_cnt <= r_lat_cnt + 1'b1;
      if (w_lat_done) r_rsp_data <= alu_result;
    end
  end

  assign alu_opcode = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_id     = r_id;
  assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a registered ALU stand-in, a transaction-level model
// compared every falling edge, and directed scenarios with literal expectations.
module tb_alu_req_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int OW  = 3;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_opcode;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [OW-1:0]   alu_opcode;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [DW-1:0]   alu_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int g_id[$];
  int g_cyc[$];
  int rsp_ids[$];

  alu_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Datapath stand-in: one-cycle registered result.
  always @(posedge clk) alu_result <= alu_fn(alu_opcode, alu_a, alu_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: an operation is "in flight" from accept until its response handshake;
  // age counts cycles since the accept edge.
  bit            m_busy;
  int            m_age;
  int            m_rr;
  int            m_id;
  int            m_win;
  int            m_j;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a;
  logic [DW-1:0] m_b;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_ready;
  logic          m_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_rr = 0; m_id = 0;
      m_op = '0; m_a = '0; m_b = '0; m_data = '0;
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end else begin
      m_win = -1;
      m_ready = '0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          m_j = (m_rr + k) % N;
          if (m_win < 0 && req_valid[m_j]) m_win = m_j;
        end
        if (m_win >= 0) m_ready[m_win] = 1'b1;
      end
      m_rsp = m_busy && (m_age >= LAT + 2);
      chk("req_ready", req_ready, m_ready);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) begin
          g_id.push_back(k);
          g_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) rsp_ids.push_back(int'(rsp_id));
      if (m_win >= 0) begin
        m_busy = 1; m_age = 1; m_id = m_win; m_rr = (m_win + 1) % N;
        m_op = req_opcode[m_win*OW +: OW];
        m_a  = req_a[m_win*DW +: DW];
        m_b  = req_b[m_win*DW +: DW];
      end else if (m_busy) begin
        if (m_rsp) begin
          if (rsp_ready) m_busy = 0;
        end else begin
          if (m_age == LAT + 1) m_data = alu_fn(m_op, m_a, m_b);
          m_age++;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_opcode[i*OW +: OW] = op;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk(nm, rsp_valid, 1);
  endtask

  task automatic wait_grant(input string nm, input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 20);
    chk(nm, req_ready[i], 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int gb, rb, cnt;
    logic [N-1:0] exp_v;
    req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // 1: reset held with no requests
    repeat (10) @(posedge clk);
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_alu_a", alu_a, 0);
    chk("t1_alu_b", alu_b, 0);
    rst_n = 1'b1;

    // 2: single add from requester 1
    rsp_ready = 1'b1;
    set_req(1, 3'd0, 16'h0003, 16'h0004);
    #1;
    exp_v = 4'b0010;
    chk("t2_grant", req_ready, exp_v);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_ready_pulse", req_ready, 0);
    chk("t2_busy_exec", busy, 1);
    @(negedge clk);
    chk("t2_no_early_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_id", rsp_id, 1);
    chk("t2_rsp_data", rsp_data, 16'h0007);
    @(negedge clk);
    chk("t2_busy_low", busy, 0);

    // brief reset so the round-robin pointer restarts at 0
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // 3: all four requesting continuously
    gb = g_id.size();
    rb = rsp_ids.size();
    for (int i = 0; i < N; i++) set_req(i, OW'(i), DW'(16'h1100 * (i + 1)), DW'(16'h0101 + i));
    repeat (17) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    drain(4);
    chk("t3_grant_count", g_id.size() - gb, 5);
    chk("t3_rsp_count", rsp_ids.size() - rb, 5);
    if (g_id.size() - gb == 5 && rsp_ids.size() - rb == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t3_grant_order", g_id[gb + k], k % N);
        chk("t3_rsp_order", rsp_ids[rb + k], k % N);
        if (k > 0) chk("t3_grant_spacing", g_cyc[gb + k] - g_cyc[gb + k - 1], 4);
      end
    end

    // 4: overflowing add with response backpressure; requester 0 waits
    rsp_ready = 1'b0;
    set_req(2, 3'd0, 16'hFFFF, 16'h0001);
    set_req(0, 3'd0, 16'h0005, 16'h0006);
    #1;
    exp_v = 4'b0100;
    chk("t4_grant2_first", req_ready, exp_v);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_rsp("t4_rsp_arrives");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_rsp_hold", rsp_valid, 1);
      chk("t4_rsp_data", rsp_data, 16'h0000);
      chk("t4_rsp_id", rsp_id, 2);
      chk("t4_req0_waits", req_ready[0], 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    gb = g_id.size();
    wait_grant("t4_grant0_after", 0);
    chk("t4_grant0_id", (g_id.size() > gb) ? g_id[gb] : -1, 0);
    drain(4);

    // 5: async reset in the middle of EXEC
    set_req(1, 3'd1, 16'h0009, 16'h0002);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy_clr", busy, 0);
    chk("t5_rsp_clr", rsp_valid, 0);
    chk("t5_alu_a_clr", alu_a, 0);
    chk("t5_alu_op_clr", alu_opcode, 0);
    rb = rsp_ids.size();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    drain(4);
    chk("t5_no_rsp", rsp_ids.size() - rb, 0);
    @(posedge clk); #1;
    set_req(3, 3'd2, 16'h00F0, 16'h0FF0);
    set_req(0, 3'd3, 16'h1234, 16'h00FF);
    #1;
    exp_v = 4'b0001;
    chk("t5_rr_restart", req_ready, exp_v);
    @(posedge clk); #1;
    req_valid = '0;
    drain(4);

    // 6: requester 3 pulses valid during RESP only
    rsp_ready = 1'b0;
    set_req(2, 3'd2, 16'hA5A5, 16'h0FF0);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_rsp("t6_rsp_arrives");
    @(posedge clk); #1;
    set_req(3, 3'd0, 16'h0001, 16'h0001);
    @(negedge clk);
    chk("t6_no_grant_in_resp", req_ready[3], 0);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    cnt = g_id.size();
    rsp_ready = 1'b1;
    drain(4);
    chk("t6_no_op_issued", g_id.size() - cnt, 0);
    chk("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end
endmodule
